// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the two-port memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_DMA = 1'b1
    } req_id_t;

    // The top address bit selects the ROM half of the map.
    function automatic logic is_rom(input logic [31:0] addr, input int unsigned addr_w);
        logic [4:0] msb;
        msb = 5'(addr_w - 32'd1);
        return addr[msb];
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signal bundle of the arbiter.
interface mem_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              cpu_req;
    logic [ADDR_W-1:0] cpu_addr;
    logic              cpu_we;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_err;

    logic              dma_req;
    logic [ADDR_W-1:0] dma_addr;
    logic              dma_we;
    logic [DATA_W-1:0] dma_wdata;
    logic              dma_ack;
    logic [DATA_W-1:0] dma_rdata;
    logic              dma_err;
    logic              dma_lock;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    modport slave (
        input  cpu_req, cpu_addr, cpu_we, cpu_wdata,
        input  dma_req, dma_addr, dma_we, dma_wdata, dma_lock,
        input  mem_rdata,
        output cpu_ack, cpu_rdata, cpu_err,
        output dma_ack, dma_rdata, dma_err,
        output mem_addr, mem_we, mem_wdata, busy
    );

    modport master (
        output cpu_req, cpu_addr, cpu_we, cpu_wdata,
        output dma_req, dma_addr, dma_we, dma_wdata, dma_lock,
        output mem_rdata,
        input  cpu_ack, cpu_rdata, cpu_err,
        input  dma_ack, dma_rdata, dma_err,
        input  mem_addr, mem_we, mem_wdata, busy
    );

endinterface

// File: rtl/mem_arb_pick.sv
// Two-way round-robin picker; a held DMA lock keeps DMA ahead after a DMA grant.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic    cpu_req,
    input  logic    dma_req,
    input  logic    dma_lock,
    input  req_id_t last_gnt,
    output logic    valid,
    output req_id_t winner
);

    // Winner selection over the current requests.
    always_comb begin
        valid  = cpu_req | dma_req;
        winner = REQ_CPU;
        if (cpu_req && dma_req) begin
            if (dma_lock && (last_gnt == REQ_DMA)) begin
                winner = REQ_DMA;
            end else if (last_gnt == REQ_CPU) begin
                winner = REQ_DMA;
            end else begin
                winner = REQ_CPU;
            end
        end else if (dma_req) begin
            winner = REQ_DMA;
        end else begin
            winner = REQ_CPU;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between CPU and DMA through an
// IDLE/ACCESS/RESP sequencer with ROM write protection.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter bit PROTECT_ROM = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus
);

    state_t            state_q,     state_d;
    req_id_t           gnt_q,       gnt_d;
    req_id_t           last_gnt_q,  last_gnt_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic              mem_we_q,    mem_we_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              blocked_q,   blocked_d;
    logic              cpu_ack_q,   cpu_ack_d;
    logic              cpu_err_q,   cpu_err_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic              dma_ack_q,   dma_ack_d;
    logic              dma_err_q,   dma_err_d;
    logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;
    logic              busy_q,      busy_d;

    logic              pick_valid_s;
    req_id_t           pick_winner_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic              sel_we_s;
    logic [DATA_W-1:0] sel_wdata_s;
    logic              sel_rom_s;

    mem_arb_pick u_pick (
        .cpu_req  (bus.cpu_req),
        .dma_req  (bus.dma_req),
        .dma_lock (bus.dma_lock),
        .last_gnt (last_gnt_q),
        .valid    (pick_valid_s),
        .winner   (pick_winner_s)
    );

    // Request-field mux for the candidate winner.
    always_comb begin
        if (pick_winner_s == REQ_DMA) begin
            sel_addr_s  = bus.dma_addr;
            sel_we_s    = bus.dma_we;
            sel_wdata_s = bus.dma_wdata;
        end else begin
            sel_addr_s  = bus.cpu_addr;
            sel_we_s    = bus.cpu_we;
            sel_wdata_s = bus.cpu_wdata;
        end
        sel_rom_s = is_rom(32'(sel_addr_s), ADDR_W);
    end

    // Sequencer next-state and response logic.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        last_gnt_d  = last_gnt_q;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = mem_we_q;
        mem_wdata_d = mem_wdata_q;
        blocked_d   = blocked_q;
        cpu_ack_d   = cpu_ack_q;
        cpu_err_d   = cpu_err_q;
        cpu_rdata_d = cpu_rdata_q;
        dma_ack_d   = dma_ack_q;
        dma_err_d   = dma_err_q;
        dma_rdata_d = dma_rdata_q;
        busy_d      = busy_q;
        case (state_q)
            IDLE: begin
                if (pick_valid_s) begin
                    gnt_d       = pick_winner_s;
                    mem_addr_d  = sel_addr_s;
                    mem_wdata_d = sel_wdata_s;
                    blocked_d   = sel_we_s & PROTECT_ROM & sel_rom_s;
                    mem_we_d    = sel_we_s & ~(PROTECT_ROM & sel_rom_s);
                    busy_d      = 1'b1;
                    state_d     = ACCESS;
                end else begin
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                end
            end
            ACCESS: begin
                // The write commits on this edge, so the strobe drops here.
                mem_we_d   = 1'b0;
                last_gnt_d = gnt_q;
                busy_d     = 1'b1;
                state_d    = RESP;
                if (gnt_q == REQ_DMA) begin
                    dma_rdata_d = bus.mem_rdata;
                    dma_ack_d   = 1'b1;
                    dma_err_d   = blocked_q;
                end else begin
                    cpu_rdata_d = bus.mem_rdata;
                    cpu_ack_d   = 1'b1;
                    cpu_err_d   = blocked_q;
                end
            end
            RESP: begin
                cpu_ack_d = 1'b0;
                cpu_err_d = 1'b0;
                dma_ack_d = 1'b0;
                dma_err_d = 1'b0;
                mem_we_d  = 1'b0;
                busy_d    = 1'b0;
                state_d   = IDLE;
            end
            default: begin
                cpu_ack_d = 1'b0;
                cpu_err_d = 1'b0;
                dma_ack_d = 1'b0;
                dma_err_d = 1'b0;
                mem_we_d  = 1'b0;
                busy_d    = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any in-flight access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            gnt_q       <= REQ_CPU;
            last_gnt_q  <= REQ_DMA;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            blocked_q   <= 1'b0;
            cpu_ack_q   <= 1'b0;
            cpu_err_q   <= 1'b0;
            cpu_rdata_q <= '0;
            dma_ack_q   <= 1'b0;
            dma_err_q   <= 1'b0;
            dma_rdata_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            last_gnt_q  <= last_gnt_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            blocked_q   <= blocked_d;
            cpu_ack_q   <= cpu_ack_d;
            cpu_err_q   <= cpu_err_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_ack_q   <= dma_ack_d;
            dma_err_q   <= dma_err_d;
            dma_rdata_q <= dma_rdata_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.cpu_ack   = cpu_ack_q;
    assign bus.cpu_err   = cpu_err_q;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.dma_ack   = dma_ack_q;
    assign bus.dma_err   = dma_err_q;
    assign bus.dma_rdata = dma_rdata_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scenario bench for mem_arbiter with a behavioural 256-byte memory whose
// upper half is preloaded with ROM content.
module tb_mem_arbiter;

    localparam int AW   = 8;
    localparam int DW   = 8;
    localparam bit PROT = 1'b1;

    typedef struct packed {
        logic [7:0] rdata;
        logic       err;
    } resp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic mem_init;
    int   checks = 0;
    int   errors = 0;

    logic [7:0] mem     [256];
    logic [7:0] exp_mem [256];
    resp_t      cpu_q[$];
    resp_t      dma_q[$];

    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .PROTECT_ROM(PROT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [7:0] rom_val(input logic [7:0] a);
        return a ^ 8'h5A;
    endfunction

    always @(posedge clk or posedge mem_init) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= (i >= 128) ? rom_val(8'(i)) : 8'h00;
        end else if (bus.mem_we) begin
            mem[bus.mem_addr] <= bus.mem_wdata;
        end
    end

    assign bus.mem_rdata = mem[bus.mem_addr];

    // Expected response of one access; updates the reference memory.
    function automatic resp_t model(input logic [7:0] a, input logic w, input logic [7:0] d);
        resp_t r;
        r.rdata = exp_mem[a];
        r.err   = 1'b0;
        if (w && PROT && a[7]) r.err = 1'b1;
        else if (w) exp_mem[a] = d;
        return r;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.cpu_ack, bus.cpu_err, bus.dma_ack, bus.dma_err, bus.mem_we, bus.busy} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b exp 000000",
                     {bus.cpu_ack, bus.cpu_err, bus.dma_ack, bus.dma_err, bus.mem_we, bus.busy});
        end
        checks++;
        if ({bus.mem_addr, bus.mem_wdata, bus.cpu_rdata, bus.dma_rdata} !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: got %h exp 0",
                     {bus.mem_addr, bus.mem_wdata, bus.cpu_rdata, bus.dma_rdata});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // One isolated CPU access, called and returning on a negedge in IDLE.
    task automatic cpu_txn(input logic [7:0] a, input logic w, input logic [7:0] d);
        resp_t e;
        int    we_cnt;
        bit    got;
        logic  exp_we;
        cpu_q.push_back(model(a, w, d));
        exp_we = w & ~(PROT & a[7]);
        bus.cpu_addr = a; bus.cpu_we = w; bus.cpu_wdata = d; bus.cpu_req = 1'b1;
        we_cnt = 0; got = 1'b0;
        for (int i = 1; i <= 8 && !got; i++) begin
            @(negedge clk);
            if (bus.mem_we) we_cnt++;
            if (i == 1) begin
                checks++;
                if (bus.busy !== 1'b1 || bus.mem_addr !== a) begin
                    errors++;
                    $display("FAIL access_phase: busy %b addr %h exp busy 1 addr %h", bus.busy, bus.mem_addr, a);
                end
            end
            if (bus.cpu_ack) begin
                got = 1'b1;
                bus.cpu_req = 1'b0;
                e = cpu_q.pop_front();
                checks++;
                if (i != 2) begin
                    errors++;
                    $display("FAIL cpu_latency: got %0d exp 2", i);
                end
                checks++;
                if (bus.cpu_rdata !== e.rdata || bus.cpu_err !== e.err) begin
                    errors++;
                    $display("FAIL cpu_resp a=%h: got rdata %h err %b exp rdata %h err %b",
                             a, bus.cpu_rdata, bus.cpu_err, e.rdata, e.err);
                end
            end
        end
        bus.cpu_req = 1'b0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL cpu_timeout a=%h: got no ack exp ack", a);
            cpu_q.delete();
        end
        @(negedge clk);
        checks++;
        if (we_cnt != int'(exp_we)) begin
            errors++;
            $display("FAIL mem_we_cycles a=%h: got %0d exp %0d", a, we_cnt, exp_we);
        end
        checks++;
        if (bus.cpu_ack !== 1'b0 || bus.cpu_err !== 1'b0 || bus.cpu_rdata !== e.rdata) begin
            errors++;
            $display("FAIL cpu_after_ack: got ack %b err %b rdata %h exp 0 0 %h",
                     bus.cpu_ack, bus.cpu_err, bus.cpu_rdata, e.rdata);
        end
    endtask

    task automatic test_single();
        cpu_txn(8'h05, 1'b1, 8'h3C);
        cpu_txn(8'h05, 1'b0, 8'h00);
    endtask

    task automatic test_simultaneous();
        resp_t e;
        int    n_acks, cpu_left, dma_left;
        bit    exp_dma;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus.cpu_addr = 8'h01; bus.cpu_we = 1'b0; bus.cpu_wdata = 8'h00;
        bus.dma_addr = 8'h10; bus.dma_we = 1'b1; bus.dma_wdata = 8'h02;
        cpu_q.push_back(model(8'h01, 1'b0, 8'h00));
        dma_q.push_back(model(8'h10, 1'b1, 8'h02));
        bus.cpu_req = 1'b1; bus.dma_req = 1'b1;
        n_acks = 0; cpu_left = 3; dma_left = 3;
        for (int i = 1; i <= 30 && n_acks < 6; i++) begin
            @(negedge clk);
            if (bus.cpu_ack || bus.dma_ack) begin
                exp_dma = (n_acks % 2) == 1;
                checks++;
                if (i != 2 + 3 * n_acks) begin
                    errors++;
                    $display("FAIL rr_timing #%0d: got cycle %0d exp %0d", n_acks, i, 2 + 3 * n_acks);
                end
                checks++;
                if (bus.dma_ack !== exp_dma || bus.cpu_ack !== !exp_dma) begin
                    errors++;
                    $display("FAIL rr_order #%0d: got cpu %b dma %b exp dma %b", n_acks, bus.cpu_ack, bus.dma_ack, exp_dma);
                end
                if (bus.cpu_ack && cpu_q.size() > 0) begin
                    e = cpu_q.pop_front();
                    checks++;
                    if (bus.cpu_rdata !== e.rdata || bus.cpu_err !== e.err) begin
                        errors++;
                        $display("FAIL rr_cpu_data: got %h/%b exp %h/%b", bus.cpu_rdata, bus.cpu_err, e.rdata, e.err);
                    end
                    cpu_left--;
                    if (cpu_left == 0) bus.cpu_req = 1'b0;
                    else cpu_q.push_back(model(8'h01, 1'b0, 8'h00));
                end
                if (bus.dma_ack && dma_q.size() > 0) begin
                    e = dma_q.pop_front();
                    checks++;
                    if (bus.dma_rdata !== e.rdata || bus.dma_err !== e.err) begin
                        errors++;
                        $display("FAIL rr_dma_data: got %h/%b exp %h/%b", bus.dma_rdata, bus.dma_err, e.rdata, e.err);
                    end
                    dma_left--;
                    if (dma_left == 0) bus.dma_req = 1'b0;
                    else dma_q.push_back(model(8'h10, 1'b1, 8'h02));
                end
                n_acks++;
            end
        end
        checks++;
        if (n_acks != 6) begin
            errors++;
            $display("FAIL rr_timeout: got %0d acks exp 6", n_acks);
        end
        bus.cpu_req = 1'b0; bus.dma_req = 1'b0;
        cpu_q.delete(); dma_q.delete();
        @(negedge clk);
    endtask

    task automatic test_dma_lock();
        resp_t e;
        int    dcount;
        bit    cpu_done;
        bus.cpu_addr = 8'h05; bus.cpu_we = 1'b0;
        cpu_q.push_back(model(8'h05, 1'b0, 8'h00));
        bus.dma_addr = 8'h20; bus.dma_we = 1'b1; bus.dma_wdata = 8'hA0;
        dma_q.push_back(model(8'h20, 1'b1, 8'hA0));
        bus.dma_lock = 1'b1; bus.cpu_req = 1'b1; bus.dma_req = 1'b1;
        dcount = 0; cpu_done = 1'b0;
        for (int i = 1; i <= 30 && !cpu_done; i++) begin
            @(negedge clk);
            if (bus.dma_ack && dma_q.size() > 0) begin
                e = dma_q.pop_front();
                checks++;
                if (i != 2 + 3 * dcount || bus.dma_rdata !== e.rdata || bus.dma_err !== e.err) begin
                    errors++;
                    $display("FAIL lock_dma #%0d: got cycle %0d rdata %h err %b exp cycle %0d rdata %h err %b",
                             dcount, i, bus.dma_rdata, bus.dma_err, 2 + 3 * dcount, e.rdata, e.err);
                end
                dcount++;
                if (dcount < 4) begin
                    bus.dma_addr  = 8'h20 + 8'(dcount);
                    bus.dma_wdata = 8'hA0 + 8'(dcount);
                    dma_q.push_back(model(bus.dma_addr, 1'b1, bus.dma_wdata));
                end else begin
                    bus.dma_req = 1'b0; bus.dma_lock = 1'b0;
                end
            end
            if (bus.cpu_ack) begin
                cpu_done = 1'b1;
                bus.cpu_req = 1'b0;
                checks++;
                if (dcount != 4 || i != 14) begin
                    errors++;
                    $display("FAIL lock_cpu_after: got dma acks %0d cycle %0d exp 4 14", dcount, i);
                end
                if (cpu_q.size() > 0) begin
                    e = cpu_q.pop_front();
                    checks++;
                    if (bus.cpu_rdata !== e.rdata) begin
                        errors++;
                        $display("FAIL lock_cpu_data: got %h exp %h", bus.cpu_rdata, e.rdata);
                    end
                end
            end
        end
        checks++;
        if (!cpu_done) begin
            errors++;
            $display("FAIL lock_timeout: got no cpu ack exp ack");
        end
        bus.cpu_req = 1'b0; bus.dma_req = 1'b0; bus.dma_lock = 1'b0;
        cpu_q.delete(); dma_q.delete();
        @(negedge clk);
        cpu_txn(8'h22, 1'b0, 8'h00);
    endtask

    task automatic test_rom_protect();
        cpu_txn(8'h85, 1'b1, 8'hFF);
        cpu_txn(8'h85, 1'b0, 8'h00);
        cpu_txn(8'h7F, 1'b1, 8'h11);
        cpu_txn(8'h80, 1'b1, 8'h22);
        cpu_txn(8'h80, 1'b0, 8'h00);
    endtask

    task automatic test_reset_access();
        resp_t e;
        int    n_acks;
        bus.cpu_addr = 8'h06; bus.cpu_we = 1'b1; bus.cpu_wdata = 8'h77; bus.cpu_req = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.mem_we !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre_access: got mem_we %b exp 1", bus.mem_we);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.mem_we, bus.busy, bus.cpu_ack, bus.cpu_err, bus.mem_addr, bus.mem_wdata} !== 20'h0) begin
            errors++;
            $display("FAIL rst_async: got %h exp 0",
                     {bus.mem_we, bus.busy, bus.cpu_ack, bus.cpu_err, bus.mem_addr, bus.mem_wdata});
        end
        bus.cpu_req = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (bus.cpu_ack !== 1'b0 || bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL rst_no_ack: got ack %b busy %b exp 0 0", bus.cpu_ack, bus.busy);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        bus.cpu_addr = 8'h06; bus.cpu_we = 1'b0;
        bus.dma_addr = 8'h22; bus.dma_we = 1'b0;
        cpu_q.push_back(model(8'h06, 1'b0, 8'h00));
        dma_q.push_back(model(8'h22, 1'b0, 8'h00));
        bus.cpu_req = 1'b1; bus.dma_req = 1'b1;
        n_acks = 0;
        for (int i = 1; i <= 20 && n_acks < 2; i++) begin
            @(negedge clk);
            if (bus.cpu_ack && cpu_q.size() > 0) begin
                e = cpu_q.pop_front();
                bus.cpu_req = 1'b0;
                checks++;
                if (i != 2 || bus.cpu_rdata !== e.rdata) begin
                    errors++;
                    $display("FAIL rst_cpu_first: got cycle %0d rdata %h exp cycle 2 rdata %h", i, bus.cpu_rdata, e.rdata);
                end
                n_acks++;
            end
            if (bus.dma_ack && dma_q.size() > 0) begin
                e = dma_q.pop_front();
                bus.dma_req = 1'b0;
                checks++;
                if (i != 5 || bus.dma_rdata !== e.rdata) begin
                    errors++;
                    $display("FAIL rst_dma_second: got cycle %0d rdata %h exp cycle 5 rdata %h", i, bus.dma_rdata, e.rdata);
                end
                n_acks++;
            end
        end
        checks++;
        if (n_acks != 2) begin
            errors++;
            $display("FAIL rst_timeout: got %0d acks exp 2", n_acks);
        end
        bus.cpu_req = 1'b0; bus.dma_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        bus.cpu_req = 1'b0; bus.cpu_addr = 8'h00; bus.cpu_we = 1'b0; bus.cpu_wdata = 8'h00;
        bus.dma_req = 1'b0; bus.dma_addr = 8'h00; bus.dma_we = 1'b0; bus.dma_wdata = 8'h00;
        bus.dma_lock = 1'b0;
        rst_n = 1'b0;
        mem_init = 1'b0;
        for (int i = 0; i < 256; i++) exp_mem[i] = (i >= 128) ? rom_val(8'(i)) : 8'h00;
        #1 mem_init = 1'b1;
        #1 mem_init = 1'b0;
        test_reset();
        test_single();
        test_simultaneous();
        test_dma_lock();
        test_rom_protect();
        test_reset_access();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the 8-bit CPU's single-port `memory` block between the CPU core and a DMA/loader requester. It serialises accesses through a three-state access sequencer with round-robin priority, an optional DMA burst lock, and write protection for the ROM half of the address space. It drives the memory's `address_bus`, `write_enable` and `from_cpu` inputs, and registers the memory's combinational `to_cpu` read data back to the granted requester.

## Interface
- `ADDR_W`, 8, address width; bit `ADDR_W-1` selects ROM (1) or RAM (0)
- `DATA_W`, 8, data width
- `PROTECT_ROM`, 1, when 1, writes to the ROM half are blocked and flagged
- `clk` in 1: single clock; all logic on the rising edge
- `rst_n` in 1: reset, asynchronous, active-low
- `cpu_req` in 1: CPU request; held with `cpu_addr`/`cpu_we`/`cpu_wdata` stable until `cpu_ack`
- `cpu_addr` in ADDR_W, `cpu_we` in 1, `cpu_wdata` in DATA_W: CPU request fields
- `cpu_ack` out 1: one-cycle completion pulse
- `cpu_rdata` out DATA_W: read data, valid while `cpu_ack`=1
- `cpu_err` out 1: pulses with `cpu_ack` on a blocked ROM write
- `dma_req`, `dma_addr`, `dma_we`, `dma_wdata`, `dma_ack`, `dma_rdata`, `dma_err`: same as the CPU set
- `dma_lock` in 1: while high, DMA keeps priority between its accesses
- `mem_addr` out ADDR_W: to memory `address_bus`
- `mem_we` out 1: to memory `write_enable`
- `mem_wdata` out DATA_W: to memory `from_cpu`
- `mem_rdata` in DATA_W: from memory `to_cpu` (combinational)
- `busy` out 1: high in ACCESS and RESP

## Operation
- States: IDLE, ACCESS, RESP.
- **IDLE.** If any request is asserted, register the winner's id into `gnt`. Register its address and data into `mem_addr`/`mem_wdata`. Set `mem_we` to the requester's `we`, except force it to 0 when `PROTECT_ROM` and addr[ADDR_W-1]=1. Go to ACCESS. With no request, stay in IDLE.
- **Winner selection.**
  - Only one requester asserted: it wins.
  - Both asserted: if `dma_lock`=1 and the last grant was DMA, DMA wins. Otherwise the requester that is not `last_gnt` wins.
- **ACCESS.**
  - The memory performs the write at the end of this cycle.
  - `mem_rdata` is captured into the granted port's `rdata` register.
  - Set the granted port's `ack`, and set its `err` if it was a blocked write.
  - Update `last_gnt` to `gnt`.
  - Go to RESP.
- **RESP.** `ack`/`err` are high for exactly this cycle. The requester drops `req` or changes its request fields on this edge. Requests are ignored in RESP. Clear `ack`, `err` and `mem_we`, then go to IDLE.
- **Reads.** `rdata` holds its last value after the ack until that port's next access.
- **Blocked writes.** A write blocked by `PROTECT_ROM` returns `rdata` equal to the current ROM content at that address.
- **Reset values.** State IDLE; `last_gnt`=DMA, so the CPU wins the first tie. All acks, errs, `mem_we`, `mem_addr`, `mem_wdata`, both `rdata` and `busy` are 0.
- **Reset mid-operation.** Any in-flight access is abandoned and no ack is issued. A write is not performed unless the ACCESS edge has already occurred.

## Timing
- `req` sampled at edge E0 (IDLE) gives memory signals valid during cycle E0–E1. The write commits at E1, and `ack` is high during E1–E2.
- Request-to-ack latency: 2 cycles. Throughput: 1 access per 3 cycles.
- `mem_we` is high only during ACCESS, and is a flop output (glitch-free).
- A request arriving during ACCESS or RESP waits; it is sampled in the next IDLE cycle.
- Requests dropped before being granted are legal. A request dropped while in ACCESS is still completed and acked.

## Structure
- Package `mem_arb_pkg`:
  - `state_t` enum {IDLE, ACCESS, RESP}
  - `req_id_t` enum {REQ_CPU, REQ_DMA}
  - helper function `is_rom(addr)`
- Sub-module `mem_arb_pick`: combinational two-way round-robin picker with lock. Inputs: `cpu_req`, `dma_req`, `dma_lock`, `last_gnt`. Outputs: `valid`, `winner`.
- The top level holds the FSM, request-field mux, output registers and the per-port response registers.

## Test plan
- **Single CPU write then read:** write 0x3C at RAM 0x05, then read 0x05. Required: `mem_we` high for 1 cycle, `cpu_ack` 2 cycles after `req`, `cpu_rdata`=0x3C, `cpu_err`=0.
- **Simultaneous requests from reset:** both `req` asserted at once, with CPU reading 0x01 and DMA writing 0x02. Required: CPU served first (ack at +2), DMA ack at +5, and the order alternates while both are held.
- **DMA lock:** `dma_lock`=1 with DMA writing 4 consecutive RAM addresses while `cpu_req` is held. Required: all 4 DMA acks arrive before `cpu_ack`. After lock is dropped, CPU is served next.
- **ROM write protection:** CPU writes 0xFF to 0x85 with `PROTECT_ROM`=1. Required: `mem_we` stays 0, `cpu_ack`=`cpu_err`=1 for one cycle, and a subsequent read of 0x85 returns the unchanged ROM value.
- **Async reset in ACCESS:** assert `rst_n`=0 mid-cycle during a CPU write. Required: all outputs go to 0 immediately with no `cpu_ack`, and the FSM restarts in IDLE with CPU priority.
